// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state encodings and default parameters for the two-requester mux arbiter.
package mux_arb_pkg;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_HOLD_MAX = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2} state_t;
    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;
endpackage

// File: rtl/mux2w.sv
// mux2w: WIDTH-bit 2:1 multiplexer, s=0 selects a, s=1 selects b.
module mux2w
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? b : a;
endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin two-requester arbiter driving a registered shared mux.
// Define ARB_HOLD_LIMIT_EN to cap a contested tenure at HOLD_MAX grant cycles.
module mux2_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             s,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);
    state_t           state, nxt;
    owner_t           last_gnt;
    logic [WIDTH-1:0] mux_y;
    logic             own_req, oth_req, hand_off, granted;

    assign granted = state == GNT_A || state == GNT_B;
    assign own_req = state == GNT_A ? req_a : req_b;
    assign oth_req = state == GNT_A ? req_b : req_a;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
    logic [CW-1:0] cnt;
    // cnt saturates at HOLD_MAX-1, so a request arriving late in a long tenure preempts on the next edge
    assign hand_off = oth_req && cnt == CW'(HOLD_MAX - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= nxt != state ? '0 : (granted && cnt != CW'(HOLD_MAX - 1)) ? cnt + CW'(1) : cnt;
    end
`else
    assign hand_off = 1'b0;
`endif

    always_comb begin
        nxt = state;
        if (!granted)
            nxt = (req_a && req_b) ? (last_gnt == OWN_A ? GNT_B : GNT_A) :
                  req_a ? GNT_A : req_b ? GNT_B : IDLE;
        else if (!own_req || hand_off)
            nxt = oth_req ? (state == GNT_A ? GNT_B : GNT_A) : IDLE;
    end

    mux2w #(.WIDTH(WIDTH)) u_mux (.a(a), .b(b), .s(s), .y(mux_y));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            s        <= 1'b0;
            y        <= '0;
            y_valid  <= 1'b0;
            last_gnt <= OWN_B;
        end else begin
            state   <= nxt;
            gnt_a   <= nxt == GNT_A;
            gnt_b   <= nxt == GNT_B;
            s       <= nxt == GNT_B ? 1'b1 : nxt == GNT_A ? 1'b0 : s;
            y_valid <= granted;
            if (granted)
                y <= mux_y;
            if (nxt != state && nxt != IDLE)
                last_gnt <= nxt == GNT_A ? OWN_A : OWN_B;
        end
    end
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: randomized and directed checks of mux2_arbiter against an owner-level model.
module tb_mux2_arbiter;
    localparam int W  = 8;
    localparam int HM = 4;

    logic         clk = 0, reset = 1, req_a = 0, req_b = 0;
    logic [W-1:0] a = '0, b = '0;
    logic         gnt_a, gnt_b, s, y_valid;
    logic [W-1:0] y;

    mux2_arbiter #(.WIDTH(W), .HOLD_MAX(HM)) dut (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .s(s), .y(y), .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: owner 0=none, 1=A, 2=B; ten = grant cycles spent in the current tenure
    int           own = 0, last = 2, ten = 0, nxt = 0;
    logic         mine, oth;
    logic [W-1:0] my = '0;
    logic         mv = 0, ms = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            own = 0; last = 2; ten = 0; my = '0; mv = 0; ms = 0;
        end else begin
            mine = own == 1 ? req_a : req_b;
            oth  = own == 1 ? req_b : req_a;
            if (own == 0)
                nxt = (req_a && req_b) ? 3 - last : req_a ? 1 : req_b ? 2 : 0;
            else
                nxt = !mine ? (oth ? 3 - own : 0) : own;
`ifdef ARB_HOLD_LIMIT_EN
            if (own != 0 && mine && oth && ten >= HM) nxt = 3 - own;
`endif
            mv = own != 0;
            if (own != 0) my = own == 1 ? a : b;
            ten = nxt == 0 ? 0 : (nxt != own ? 1 : ten + 1);
            if (nxt != 0) last = nxt;
            if (nxt != 0) ms = nxt == 2;
            own = nxt;
            #1;
            chk("m_gnt_a", gnt_a, own == 1);
            chk("m_gnt_b", gnt_b, own == 2);
            chk("m_excl", gnt_a & gnt_b, 0);
            chk("m_s", s, ms);
            chk("m_y_valid", y_valid, mv);
            chk("m_y", y, my);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        repeat (2) step();
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_s", s, 0);
        chk("rst_y", y, 0);
        chk("rst_y_valid", y_valid, 0);
        reset = 0;
        // single requester A for three cycles
        req_a = 1; a = 8'hA5; b = 8'h3C;
        step(); chk("s1_g1", gnt_a, 1); chk("s1_v1", y_valid, 0); chk("s1_s1", s, 0);
        step(); chk("s1_g2", gnt_a, 1); chk("s1_v2", y_valid, 1); chk("s1_y2", y, 8'hA5);
        step(); chk("s1_g3", gnt_a, 1); chk("s1_v3", y_valid, 1); req_a = 0;
        step(); chk("s1_g4", gnt_a, 0); chk("s1_v4", y_valid, 1); chk("s1_y4", y, 8'hA5);
        step(); chk("s1_v5", y_valid, 0); chk("s1_y5", y, 8'hA5); chk("s1_s5", s, 0);
        // contested start after reset, then back-to-back handoff
        rst_pulse();
        req_a = 1; req_b = 1; a = 8'h11; b = 8'h22;
        step(); chk("s2_ga", gnt_a, 1); chk("s2_gb0", gnt_b, 0); req_a = 0;
        step(); chk("s2_ga0", gnt_a, 0); chk("s2_gb", gnt_b, 1); chk("s2_s", s, 1);
        step(); chk("s2_y", y, 8'h22); chk("s2_v", y_valid, 1); req_b = 0;
        step(); chk("s2_idle", gnt_b, 0);
        step(); chk("s2_shold", s, 1); chk("s2_v0", y_valid, 0);
        // round robin: B was last, so A wins, then B wins
        req_a = 1; req_b = 1;
        step(); chk("s3_ga", gnt_a, 1); req_a = 0; req_b = 0;
        step(); chk("s3_idle", gnt_a | gnt_b, 0); req_a = 1; req_b = 1;
        step(); chk("s3_gb", gnt_b, 1); chk("s3_ga0", gnt_a, 0); req_a = 0; req_b = 0;
        step(); step();
        // asynchronous reset in the middle of a B tenure
        req_b = 1; b = 8'h5A;
        step(); chk("s4_gb", gnt_b, 1);
        step(); chk("s4_v", y_valid, 1); chk("s4_y", y, 8'h5A);
        #2 reset = 1;
        #1;
        chk("s4_gb0", gnt_b, 0); chk("s4_v0", y_valid, 0); chk("s4_y0", y, 0); chk("s4_s0", s, 0);
        step(); reset = 0; req_b = 0;
        step();
        // both held: blocks of HM with hold limit, A forever without
        req_a = 1; req_b = 1;
        for (int i = 0; i < 3 * HM; i++) begin
            logic ea;
            step();
`ifdef ARB_HOLD_LIMIT_EN
            ea = ((i / HM) % 2) == 0;
`else
            ea = 1'b1;
`endif
            chk("s5_ga", gnt_a, ea);
            chk("s5_gb", gnt_b, !ea);
        end
        req_a = 0; req_b = 0;
        step(); step();
        // randomized traffic with occasional mid-cycle reset pulses
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0) req_a = ~req_a;
            if ($urandom_range(3) == 0) req_b = ~req_b;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(59) == 0) begin
                #2 reset = 1;
                #1 reset = 0;
            end
            step();
        end
        req_a = 0; req_b = 0;
        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
